// File: rtl/pixel_scan_generator_if.sv
// rtl/pixel_scan_generator_if.sv - pixel coordinate beat stream between the scan source and its consumer
interface pixel_scan_generator_if #(
    parameter int X_WIDTH = 10,
    parameter int Y_WIDTH = 10
);
    logic               valid;
    logic               ready;
    logic [X_WIDTH-1:0] pixel_x;
    logic [Y_WIDTH-1:0] pixel_y;
    logic               eol;
    logic               last;

    modport master (output valid, pixel_x, pixel_y, eol, last, input ready);
    modport slave  (input valid, pixel_x, pixel_y, eol, last, output ready);
endinterface

// File: rtl/pixel_scan_generator.sv
// rtl/pixel_scan_generator.sv - row-major raster scan source issuing one (x, y) beat per valid/ready transfer
module pixel_scan_generator #(
    parameter int X_WIDTH = 10,
    parameter int Y_WIDTH = 10,
    parameter int H_RES   = 640,
    parameter int V_RES   = 480
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    pixel_scan_generator_if.master        pix,
    output logic                          busy,
    output logic                          done
);
    localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(H_RES - 1);
    localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(V_RES - 1);
    localparam bit SINGLE_COL = (H_RES == 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state;

    logic [X_WIDTH-1:0] x_inc;
    logic [Y_WIDTH-1:0] y_inc;

    always_comb begin
        x_inc = pix.pixel_x + X_WIDTH'(1);
        y_inc = pix.pixel_y + Y_WIDTH'(1);
    end

    // eol/last are precomputed for the coordinate being loaded so they stay
    // aligned with it through any number of stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pix.valid   <= 1'b0;
            pix.pixel_x <= '0;
            pix.pixel_y <= '0;
            pix.eol     <= 1'b0;
            pix.last    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state       <= SCAN;
                        pix.valid   <= 1'b1;
                        pix.pixel_x <= '0;
                        pix.pixel_y <= '0;
                        pix.eol     <= SINGLE_COL;
                        pix.last    <= SINGLE_COL && (Y_LAST == '0);
                        busy        <= 1'b1;
                    end
                end
                SCAN: begin
                    if (abort || (pix.ready && pix.last)) begin
                        state       <= abort ? IDLE : DONE;
                        done        <= !abort;
                        pix.valid   <= 1'b0;
                        pix.pixel_x <= '0;
                        pix.pixel_y <= '0;
                        pix.eol     <= 1'b0;
                        pix.last    <= 1'b0;
                        busy        <= 1'b0;
                    end else if (pix.ready) begin
                        if (pix.eol) begin
                            pix.pixel_x <= '0;
                            pix.pixel_y <= y_inc;
                            pix.eol     <= SINGLE_COL;
                            pix.last    <= SINGLE_COL && (y_inc == Y_LAST);
                        end else begin
                            pix.pixel_x <= x_inc;
                            pix.eol     <= (x_inc == X_LAST);
                            pix.last    <= (x_inc == X_LAST) && (pix.pixel_y == Y_LAST);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    pix.valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_scan_generator.sv
// tb/tb_pixel_scan_generator.sv - self-checking bench for pixel_scan_generator (4x3 and 1x1 frames)
module tb_pixel_scan_generator;
    localparam int H = 4;
    localparam int V = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, abort, busy, done;
    logic start_b, abort_b, busy_b, done_b;

    pixel_scan_generator_if #(.X_WIDTH(10), .Y_WIDTH(10)) ifa ();
    pixel_scan_generator_if #(.X_WIDTH(10), .Y_WIDTH(10)) ifb ();

    pixel_scan_generator #(.X_WIDTH(10), .Y_WIDTH(10), .H_RES(H), .V_RES(V)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .pix(ifa), .busy(busy), .done(done)
    );

    pixel_scan_generator #(.X_WIDTH(10), .Y_WIDTH(10), .H_RES(1), .V_RES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .pix(ifb), .busy(busy_b), .done(done_b)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int rdy;
        int vld;
        int x;
        int y;
        int eol;
        int last;
        int done;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: the k-th delivered beat of a row-major frame.
    task automatic check_beat(input string tag, input int k);
        chk({tag, ".valid"}, ifa.valid, 1);
        chk({tag, ".x"}, ifa.pixel_x, k % H);
        chk({tag, ".y"}, ifa.pixel_y, k / H);
        chk({tag, ".eol"}, ifa.eol, (k % H) == H - 1);
        chk({tag, ".last"}, ifa.last, k == H * V - 1);
        chk({tag, ".busy"}, busy, 1);
        chk({tag, ".done"}, done, 0);
    endtask

    task automatic check_idle_a(input string tag, input int exp_done);
        chk({tag, ".valid"}, ifa.valid, 0);
        chk({tag, ".x"}, ifa.pixel_x, 0);
        chk({tag, ".y"}, ifa.pixel_y, 0);
        chk({tag, ".eol"}, ifa.eol, 0);
        chk({tag, ".last"}, ifa.last, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, exp_done);
    endtask

    // mode 0: ready=1, 1: one accept every 4 cycles, 2: random ready
    task automatic run_frame(input int mode, input bit noise);
        int  k   = 0;
        int  cyc = 0;
        int  cnt = 0;
        bit  rdy;
        start = 1'b1;
        step();
        start = 1'b0;
        while (k < H * V && cyc < 400) begin
            check_beat("frame", k);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cnt == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            cnt = (cnt + 1) % 4;
            if (noise) start = 1'($urandom_range(0, 1));
            ifa.ready = rdy;
            if (rdy) k++;
            step();
            cyc++;
        end
        start = 1'b0;
        chk("frame.beats", k, H * V);
        check_idle_a("frame_end", 1);
        ifa.ready = 1'($urandom_range(0, 1));
        step();
        check_idle_a("frame_after", 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; start_b = 1'b0; abort_b = 1'b0;
        ifa.ready = 1'b0; ifb.ready = 1'b0;
        tbl = '{
            '{1, 1, 0, 0, 0, 0, 0}, '{1, 1, 1, 0, 0, 0, 0}, '{1, 1, 2, 0, 0, 0, 0},
            '{1, 1, 3, 0, 1, 0, 0}, '{1, 1, 0, 1, 0, 0, 0}, '{1, 1, 1, 1, 0, 0, 0},
            '{1, 1, 2, 1, 0, 0, 0}, '{1, 1, 3, 1, 1, 0, 0}, '{1, 1, 0, 2, 0, 0, 0},
            '{1, 1, 1, 2, 0, 0, 0}, '{1, 1, 2, 2, 0, 0, 0}, '{1, 1, 3, 2, 1, 1, 0},
            '{1, 0, 0, 0, 0, 0, 1}, '{1, 0, 0, 0, 0, 0, 0}
        };
        step();
        step();
        check_idle_a("reset_a", 0);
        chk("reset_b.valid", ifb.valid, 0);
        chk("reset_b.busy", busy_b, 0);
        chk("reset_b.done", done_b, 0);
        #3 rst_n = 1'b1;
        step();
        check_idle_a("post_reset", 0);

        // Table-driven frame with ready tied high
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            chk($sformatf("tbl%0d.valid", i), ifa.valid, tbl[i].vld);
            chk($sformatf("tbl%0d.x", i), ifa.pixel_x, tbl[i].x);
            chk($sformatf("tbl%0d.y", i), ifa.pixel_y, tbl[i].y);
            chk($sformatf("tbl%0d.eol", i), ifa.eol, tbl[i].eol);
            chk($sformatf("tbl%0d.last", i), ifa.last, tbl[i].last);
            chk($sformatf("tbl%0d.done", i), done, tbl[i].done);
            ifa.ready = 1'(tbl[i].rdy);
            step();
        end

        run_frame(1, 1'b0);

        // start re-pulsed mid-frame and in DONE, then held into IDLE
        start = 1'b1;
        step();
        start = 1'b0;
        ifa.ready = 1'b1;
        for (int k = 0; k < H * V; k++) begin
            check_beat("restart", k);
            start = (k == 5);
            step();
        end
        check_idle_a("restart_done", 1);
        start = 1'b1;
        step();
        check_idle_a("restart_idle", 0);
        step();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check_beat("new_frame", k);
            step();
        end

        // abort on (2,1) while it transfers
        check_beat("abort_beat", 6);
        abort = 1'b1;
        step();
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_idle_a("abort_after", 0);
            step();
        end

        // asynchronous reset during beat (1,2)
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 9; k++) step();
        check_beat("pre_rst", 9);
        #3 rst_n = 1'b0;
        #1;
        check_idle_a("async_rst", 0);
        step();
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle_a("rst_release", 0);
        end

        // 1x1 frame
        ifb.ready = 1'b1;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        chk("one.valid", ifb.valid, 1);
        chk("one.x", ifb.pixel_x, 0);
        chk("one.y", ifb.pixel_y, 0);
        chk("one.eol", ifb.eol, 1);
        chk("one.last", ifb.last, 1);
        chk("one.busy", busy_b, 1);
        step();
        chk("one_end.valid", ifb.valid, 0);
        chk("one_end.done", done_b, 1);
        chk("one_end.busy", busy_b, 0);
        step();
        chk("one_idle.valid", ifb.valid, 0);
        chk("one_idle.done", done_b, 0);
        chk("one_idle.busy", busy_b, 0);

        for (int f = 0; f < 4; f++) run_frame(2, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
